// File: rtl/ex_div.sv
// ============================================================================
// Module   : ex_div
// Brief    : Multi-cycle restoring divider for the EX stage (DIV / DIVU).
//            Produces {remainder, quotient} after 32 shift-subtract steps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_div #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic            start,
    input  logic            signed_div,
    input  logic [DW-1:0]   opdata1,
    input  logic [DW-1:0]   opdata2,
    input  logic            annul,
    output logic [2*DW-1:0] result,
    output logic            ready,
    output logic            stall_req
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DIVZERO = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [5:0] c_last_step = 6'd31;

    state_t          r_state,   w_state_nxt;
    logic [5:0]      r_cnt,     w_cnt_nxt;
    logic [2*DW:0]   r_acc,     w_acc_nxt;
    logic [DW-1:0]   r_divisor, w_divisor_nxt;
    logic            r_neg_q,   w_neg_q_nxt;
    logic            r_neg_r,   w_neg_r_nxt;
    logic [2*DW-1:0] r_result,  w_result_nxt;
    logic            r_ready,   w_ready_nxt;

    logic [2*DW:0]   w_shifted;
    logic [2*DW:0]   w_step;
    logic [DW:0]     w_diff;
    logic [DW-1:0]   w_abs1;
    logic [DW-1:0]   w_abs2;
    logic [DW-1:0]   w_quot;
    logic [DW-1:0]   w_rem;

    // Magnitudes of the operands; unsigned ops pass straight through.
    assign w_abs1 = (signed_div && opdata1[DW-1]) ? -opdata1 : opdata1;
    assign w_abs2 = (signed_div && opdata2[DW-1]) ? -opdata2 : opdata2;

    // One restoring step: the partial remainder lives in the upper 33 bits,
    // dividend bits shift out of the low half as quotient bits shift in.
    assign w_shifted = r_acc << 1;
    assign w_diff    = w_shifted[2*DW:DW] - {1'b0, r_divisor};
    assign w_step    = w_diff[DW] ? w_shifted
                                  : {w_diff, w_shifted[DW-1:1], 1'b1};

    assign w_quot = r_neg_q ? -w_step[DW-1:0]    : w_step[DW-1:0];
    assign w_rem  = r_neg_r ? -w_step[2*DW-1:DW] : w_step[2*DW-1:DW];

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_acc_nxt     = r_acc;
        w_divisor_nxt = r_divisor;
        w_neg_q_nxt   = r_neg_q;
        w_neg_r_nxt   = r_neg_r;
        w_result_nxt  = r_result;
        w_ready_nxt   = r_ready;

        case (r_state)
            IDLE: begin
                w_ready_nxt  = 1'b0;
                w_result_nxt = '0;
                if (start && !annul) begin
                    if (opdata2 == '0) begin
                        w_state_nxt = DIVZERO;
                    end else begin
                        w_state_nxt   = BUSY;
                        w_cnt_nxt     = '0;
                        w_acc_nxt     = {{(DW+1){1'b0}}, w_abs1};
                        w_divisor_nxt = w_abs2;
                        w_neg_q_nxt   = signed_div & (opdata1[DW-1] ^ opdata2[DW-1]);
                        w_neg_r_nxt   = signed_div & opdata1[DW-1];
                    end
                end
            end
            BUSY: begin
                if (annul) begin
                    w_state_nxt  = IDLE;
                    w_ready_nxt  = 1'b0;
                    w_result_nxt = '0;
                end else begin
                    w_acc_nxt = w_step;
                    w_cnt_nxt = r_cnt + 6'd1;
                    if (r_cnt == c_last_step) begin
                        w_state_nxt  = DONE;
                        w_result_nxt = {w_rem, w_quot};
                        w_ready_nxt  = 1'b1;
                    end
                end
            end
            DIVZERO: begin
                w_result_nxt = '0;
                if (annul) begin
                    w_state_nxt = IDLE;
                    w_ready_nxt = 1'b0;
                end else begin
                    w_state_nxt = DONE;
                    w_ready_nxt = 1'b1;
                end
            end
            DONE: begin
                if (annul || !start) begin
                    w_state_nxt  = IDLE;
                    w_ready_nxt  = 1'b0;
                    w_result_nxt = '0;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_ready_nxt  = 1'b0;
                w_result_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_acc     <= w_acc_nxt;
            r_divisor <= w_divisor_nxt;
            r_neg_q   <= w_neg_q_nxt;
            r_neg_r   <= w_neg_r_nxt;
            r_result  <= w_result_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    assign result    = r_result;
    assign ready     = r_ready;
    assign stall_req = start & ~annul & (r_state != DONE);

endmodule

`default_nettype wire

// File: tb/tb_ex_div.sv
// ============================================================================
// Module   : tb_ex_div
// Brief    : Self-checking bench for ex_div against an arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_div;

    logic        clk;
    logic        rst_;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stall_req;

    int checks = 0;
    int errors = 0;

    ex_div #(.DW(32)) dut (
        .clk        (clk),
        .rst_       (rst_),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .stall_req  (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division; signed ops use truncating division
    // in 64 bits so the most-negative / -1 case wraps naturally.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) return 64'h0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Issue one op, hold start until ready, scrambling operands meanwhile.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int   lat;
        logic stall_bad;
        int   exp_lat;
        exp_lat   = (b == 32'd0) ? 2 : 33;
        stall_bad = 1'b0;
        @(negedge clk);
        start = 1'b1; signed_div = sgn; opdata1 = a; opdata2 = b;
        #1;
        if (!stall_req) stall_bad = 1'b1;
        lat = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (ready) break;
            if (!stall_req) stall_bad = 1'b1;
            opdata1    = $urandom;
            opdata2    = $urandom;
            signed_div = 1'($urandom);
        end
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_res"}, result, exp);
        check_eq({tag, "_stall_done"}, 64'(stall_req), 64'd0);
        check_eq({tag, "_stall_busy"}, 64'(stall_bad), 64'd0);
        @(negedge clk);
        check_eq({tag, "_hold"}, {ready, result[62:0]}, {1'b1, exp[62:0]});
        start = 1'b0;
        @(negedge clk);
        check_eq({tag, "_drop"}, {63'(ready), 1'b0} | 64'(result != 64'd0), 64'd0);
    endtask

    initial begin
        logic        ready_seen;
        logic [31:0] ra, rb;
        logic        rs;
        int          sel;

        rst_ = 1'b0; start = 1'b0; signed_div = 1'b0;
        opdata1 = '0; opdata2 = '0; annul = 1'b0;
        #1;
        check_eq("rst_ready", 64'(ready), 64'd0);
        check_eq("rst_result", result, 64'd0);
        check_eq("rst_stall", 64'(stall_req), 64'd0);
        repeat (2) @(negedge clk);
        rst_ = 1'b1;

        run_op("divu_100_7",  1'b0, 32'd100,        32'd7,          {32'd2, 32'd14});
        run_op("div_m7_2",    1'b1, 32'hFFFFFFF9,   32'h2,          {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_op("div_7_m2",    1'b1, 32'h7,          32'hFFFFFFFE,   {32'h00000001, 32'hFFFFFFFD});
        run_op("div_ovf",     1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h0, 32'h80000000});
        run_op("divu_max_1",  1'b0, 32'hFFFFFFFF,   32'h1,          {32'h0, 32'hFFFFFFFF});
        run_op("div_zero",    1'b1, 32'h12345678,   32'h0,          64'h0);

        // annul during BUSY step 10 aborts, then a fresh op completes
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; opdata1 = 32'd50; opdata2 = 32'd5;
        repeat (11) @(negedge clk);
        annul = 1'b1;
        #1;
        check_eq("annul_stall", 64'(stall_req), 64'd0);
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        check_eq("annul_out", {63'(ready), 1'b0} | 64'(result != 64'd0), 64'd0);
        ready_seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (ready) ready_seen = 1'b1;
        end
        check_eq("annul_no_ready", 64'(ready_seen), 64'd0);
        run_op("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

        // annul in IDLE blocks a same-cycle start (zero divisor would show fast)
        @(negedge clk);
        start = 1'b1; annul = 1'b1; opdata1 = 32'd1; opdata2 = 32'd0;
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        ready_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ready) ready_seen = 1'b1;
        end
        check_eq("idle_annul_block", 64'(ready_seen), 64'd0);

        // annul in DONE beats a held start
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; opdata1 = 32'd8; opdata2 = 32'd0;
        repeat (2) @(negedge clk);
        check_eq("done_pre_annul", 64'(ready), 64'd1);
        annul = 1'b1;
        @(negedge clk);
        check_eq("done_annul", 64'(ready), 64'd0);
        annul = 1'b0; start = 1'b0;
        @(negedge clk);

        // asynchronous reset between edges mid-BUSY
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; opdata1 = 32'd77; opdata2 = 32'd3;
        repeat (6) @(negedge clk);
        #2 rst_ = 1'b0;
        #1;
        check_eq("arst_out", {63'(ready), 1'b0} | 64'(result != 64'd0), 64'd0);
        @(negedge clk);
        start = 1'b0;
        #2 rst_ = 1'b1;
        run_op("divu_10_4", 1'b0, 32'd10, 32'd4, {32'd2, 32'd2});

        // randomized ops including corner operands
        for (int i = 0; i < 30; i++) begin
            sel = int'($urandom_range(0, 5));
            ra  = $urandom;
            rb  = $urandom;
            rs  = 1'($urandom);
            case (sel)
                0: rb = 32'd0;
                1: begin ra = 32'h80000000; rb = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : rb; end
                2: rb = $urandom_range(1, 17);
                3: rb = -32'($urandom_range(1, 17));
                default: ;
            endcase
            run_op("rand", rs, ra, rb, model(rs, ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 Parameter: DW, default 32, operand width; the block SHALL be correct for DW=32 only; other values are unsupported.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_  input  1  reset, asynchronous, active-low; assertion SHALL clear all state immediately regardless of clk.
REQ-004 start  input  1  EX stage holds a DIV/DIVU op; level-sensitive, held high by pipeline until ready.
REQ-005 signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start in IDLE.
REQ-006 opdata1  input  32  dividend (EX reg0 operand); sampled in IDLE.
REQ-007 opdata2  input  32  divisor (EX reg1 operand); sampled in IDLE.
REQ-008 annul  input  1  pipeline flush; aborts any operation in progress.
REQ-009 result  output  64  {remainder[63:32], quotient[31:0]}; registered.
REQ-010 ready  output  1  result valid; registered.
REQ-011 stall_req  output  1  request to freeze IF/ID/EX; combinational.

Function
REQ-012 States SHALL be IDLE, BUSY, DIVZERO, DONE; 2-bit encoding, 6-bit iteration counter cnt.
REQ-013 IDLE: start=1 and annul=0 and opdata2=0 -> DIVZERO.
REQ-014 IDLE: start=1 and annul=0 and opdata2!=0 -> BUSY, cnt=0; latch operands; if signed_div, latch |opdata1|, |opdata2| (two's-complement negate when bit 31 set) and record neg_q = op1[31]^op2[31], neg_r = op1[31].
REQ-015 IDLE: otherwise remain; ready=0, result=0.
REQ-016 BUSY: one restoring shift-subtract step per cycle on a 65-bit partial-remainder/quotient register; step: shift left 1, subtract divisor from upper 33 bits, if non-negative keep difference and set quotient LSB to 1, else restore and set 0.
REQ-017 BUSY SHALL run exactly 32 steps (cnt 0..31); on the cycle with cnt=31 the block SHALL transition to DONE and load result with the sign-corrected quotient/remainder.
REQ-018 Sign correction (signed_div only): quotient negated if neg_q; remainder negated if neg_r; unsigned ops uncorrected.
REQ-019 Overflow case 0x80000000 / 0xFFFFFFFF signed: result SHALL be quotient 0x80000000, remainder 0x00000000 (no trap).
REQ-020 DIVZERO: next cycle -> DONE with result = 64'h0.
REQ-021 DONE: ready=1, result held stable while start=1; start=0 -> IDLE with ready=0, result=0 next cycle.
REQ-022 Latency: start first seen in IDLE at cycle N -> ready=1 at cycle N+33 (nonzero divisor) or N+2 (zero divisor).
REQ-023 annul=1 in BUSY or DIVZERO -> IDLE next cycle, ready=0, result=0; annul in IDLE SHALL block a start sampled in the same cycle.
REQ-024 annul=1 in DONE -> IDLE next cycle; priority annul > start.
REQ-025 stall_req = start & ~annul & (state != DONE).
REQ-026 Operand changes on opdata1/opdata2/signed_div after IDLE sampling SHALL NOT affect the result.
REQ-027 Back-to-back: a new start only takes effect after one IDLE cycle following DONE.

Reset
REQ-028 rst_=0: state=IDLE, cnt=0, result=64'h0, ready=0, latched operands and sign flags cleared; stall_req then follows REQ-025.
REQ-029 Reset asserted mid-BUSY SHALL discard the operation; after release the block SHALL accept a fresh start from IDLE.

Verification
REQ-030 DIVU 100/7, start held -> ready at N+33, result = {32'd2, 32'd14}; stall_req high N..N+32, low at N+33.
REQ-031 DIV -7/2 (0xFFFFFFF9, 0x2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; DIV 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
REQ-032 DIV 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0; DIVU 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
REQ-033 Divisor 0, start at N -> ready at N+2, result 64'h0; start drop -> ready 0 next cycle.
REQ-034 annul at step 10 of BUSY -> IDLE next cycle, ready never asserts; following DIVU 9/3 -> {0, 3} at +33.
REQ-035 rst_ pulsed low asynchronously mid-BUSY (between clock edges) -> outputs zero immediately; subsequent DIVU 10/4 -> {2, 2}.
